// File: rtl/atri_pps_timebase.sv
// PPS-disciplined second/cycle timebase with period measurement, bounded holdover and trigger timestamping.
// One-edge latency from flag/tick/trigger to outputs; no backpressure, every input pulse is consumed.
module atri_pps_timebase #(
    parameter int CYCLE_BITS     = 32,
    parameter int SEC_BITS       = 32,
    parameter int MS_BITS        = 11,
    parameter int TIMEOUT_MS     = 1100,
    parameter int MAX_HOLDOVER_S = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  pps_flag_i,
    input  logic                  KHz_CE_i,
    input  logic                  trig_i,
    output logic [SEC_BITS-1:0]   sec_o,
    output logic [CYCLE_BITS-1:0] cyc_o,
    output logic [CYCLE_BITS-1:0] period_o,
    output logic                  period_valid_o,
    output logic                  locked_o,
    output logic                  holdover_o,
    output logic [1:0]            state_o,
    output logic                  pps_tick_o,
    output logic [SEC_BITS-1:0]   ts_sec_o,
    output logic [CYCLE_BITS-1:0] ts_cyc_o,
    output logic                  ts_valid_o
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_LOCKED   = 2'b10,
        ST_HOLDOVER = 2'b11
    } state_t;

    localparam int HO_BITS = $clog2(MAX_HOLDOVER_S + 1);
    localparam logic [CYCLE_BITS-1:0] CYC_ONE  = CYCLE_BITS'(1);
    localparam logic [SEC_BITS-1:0]   SEC_ONE  = SEC_BITS'(1);
    localparam logic [MS_BITS-1:0]    MS_ONE   = MS_BITS'(1);
    localparam logic [MS_BITS-1:0]    MS_LIMIT = MS_BITS'(TIMEOUT_MS);
    localparam logic [HO_BITS-1:0]    HO_ONE   = HO_BITS'(1);
    localparam logic [HO_BITS-1:0]    HO_LIMIT = HO_BITS'(MAX_HOLDOVER_S);

    state_t                r_state, w_state_nxt;
    logic [CYCLE_BITS-1:0] r_cyc, w_cyc_nxt;
    logic [CYCLE_BITS-1:0] r_period, w_period_nxt;
    logic                  r_pv, w_pv_nxt;
    logic [HO_BITS-1:0]    r_ho, w_ho_nxt;
    logic [SEC_BITS-1:0]   r_sec;
    logic [MS_BITS-1:0]    r_ms;
    logic                  r_tick;
    logic [SEC_BITS-1:0]   r_ts_sec;
    logic [CYCLE_BITS-1:0] r_ts_cyc;
    logic                  r_ts_vld;

    logic                  w_sec_inc;
    logic [CYCLE_BITS-1:0] w_cyc_inc;
    logic [CYCLE_BITS-1:0] w_entry_cyc;
    logic                  w_syn_tick;
    logic                  w_late_flag;
    logic                  w_timeout;

    assign w_cyc_inc   = (&r_cyc) ? r_cyc : r_cyc + CYC_ONE;
    // Entering holdover already counts one synthetic second, so carry the overshoot into the new second.
    assign w_entry_cyc = (w_cyc_inc >= r_period) ? w_cyc_inc - r_period : '0;
    assign w_syn_tick  = (r_cyc == r_period - CYC_ONE);
    assign w_late_flag = (r_cyc >= (r_period >> 1));
    assign w_timeout   = (r_ms == MS_LIMIT);

    always_comb begin
        w_state_nxt  = r_state;
        w_cyc_nxt    = w_cyc_inc;
        w_period_nxt = r_period;
        w_pv_nxt     = r_pv;
        w_ho_nxt     = r_ho;
        w_sec_inc    = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (pps_flag_i) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (pps_flag_i) begin
                    w_period_nxt = w_cyc_inc;
                    w_pv_nxt     = 1'b1;
                    w_sec_inc    = 1'b1;
                    w_cyc_nxt    = '0;
                    w_state_nxt  = ST_LOCKED;
                end else if (w_timeout) begin
                    w_state_nxt = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (pps_flag_i) begin
                    w_period_nxt = w_cyc_inc;
                    w_sec_inc    = 1'b1;
                    w_cyc_nxt    = '0;
                end else if (w_timeout) begin
                    w_sec_inc   = 1'b1;
                    w_cyc_nxt   = w_entry_cyc;
                    w_ho_nxt    = HO_ONE;
                    w_state_nxt = ST_HOLDOVER;
                end
            end
            default: begin
                // A real flag outranks both the holdover limit and a coincident synthetic tick.
                if (pps_flag_i) begin
                    w_sec_inc   = w_late_flag;
                    w_cyc_nxt   = '0;
                    w_state_nxt = ST_LOCKED;
                end else if (r_ho >= HO_LIMIT) begin
                    w_pv_nxt    = 1'b0;
                    w_state_nxt = ST_UNLOCKED;
                end else if (w_syn_tick) begin
                    w_sec_inc = 1'b1;
                    w_cyc_nxt = '0;
                    w_ho_nxt  = r_ho + HO_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_UNLOCKED;
            r_cyc    <= '0;
            r_period <= '0;
            r_pv     <= 1'b0;
            r_ho     <= '0;
            r_sec    <= '0;
            r_ms     <= '0;
            r_tick   <= 1'b0;
            r_ts_sec <= '0;
            r_ts_cyc <= '0;
            r_ts_vld <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_period <= w_period_nxt;
            r_pv     <= w_pv_nxt;
            r_ho     <= w_ho_nxt;
            r_tick   <= w_sec_inc;
            if (w_sec_inc) begin
                r_sec <= r_sec + SEC_ONE;
            end
            if (pps_flag_i || (w_state_nxt != r_state)) begin
                r_ms <= '0;
            end else if (KHz_CE_i && (r_ms < MS_LIMIT)) begin
                r_ms <= r_ms + MS_ONE;
            end
            r_ts_vld <= trig_i;
            if (trig_i) begin
                r_ts_sec <= r_sec;
                r_ts_cyc <= r_cyc;
            end
        end
    end

    assign sec_o          = r_sec;
    assign cyc_o          = r_cyc;
    assign period_o       = r_period;
    assign period_valid_o = r_pv;
    assign state_o        = r_state;
    assign locked_o       = (r_state == ST_LOCKED);
    assign holdover_o     = (r_state == ST_HOLDOVER);
    assign pps_tick_o     = r_tick;
    assign ts_sec_o       = r_ts_sec;
    assign ts_cyc_o       = r_ts_cyc;
    assign ts_valid_o     = r_ts_vld;

endmodule

// File: tb/tb_atri_pps_timebase.sv
// Bench for atri_pps_timebase: hand-computed scenario table, then random flags/CE/triggers
// compared every cycle against a second-level behavioural model.
module tb_atri_pps_timebase;

    localparam longint CMAX  = 64'h0000_0000_FFFF_FFFF;
    localparam longint SMOD  = 64'h0000_0001_0000_0000;
    localparam int     TOUT  = 110;
    localparam int     MAXH  = 3;
    localparam int     M_UNL = 0, M_ARM = 1, M_LCK = 2, M_HLD = 3;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        pps_flag_i = 1'b0;
    logic        KHz_CE_i = 1'b0;
    logic        trig_i = 1'b0;
    logic [31:0] sec_o, cyc_o, period_o, ts_sec_o, ts_cyc_o;
    logic        period_valid_o, locked_o, holdover_o, pps_tick_o, ts_valid_o;
    logic [1:0]  state_o;

    atri_pps_timebase #(
        .CYCLE_BITS(32), .SEC_BITS(32), .MS_BITS(11),
        .TIMEOUT_MS(TOUT), .MAX_HOLDOVER_S(MAXH)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .pps_flag_i(pps_flag_i), .KHz_CE_i(KHz_CE_i),
        .trig_i(trig_i), .sec_o(sec_o), .cyc_o(cyc_o), .period_o(period_o),
        .period_valid_o(period_valid_o), .locked_o(locked_o), .holdover_o(holdover_o),
        .state_o(state_o), .pps_tick_o(pps_tick_o), .ts_sec_o(ts_sec_o),
        .ts_cyc_o(ts_cyc_o), .ts_valid_o(ts_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int since_flag = 0;

    // Reference model state: whole seconds, cycles into the second, and the mode.
    int     m_mode;
    longint m_sec, m_cyc, m_per, m_ms, m_ho, m_tss, m_tsc;
    bit     m_pv, m_tick, m_tsv;

    task automatic model_reset();
        m_mode = M_UNL; m_sec = 0; m_cyc = 0; m_per = 0; m_ms = 0; m_ho = 0;
        m_tss = 0; m_tsc = 0; m_pv = 0; m_tick = 0; m_tsv = 0;
    endtask

    task automatic model_step(input bit f, input bit ce, input bit tr);
        longint c1, nc;
        int     nm;
        bit     bump;
        c1 = (m_cyc >= CMAX) ? CMAX : m_cyc + 1;
        nc = c1; nm = m_mode; bump = 0;
        if (tr) begin
            m_tss = m_sec;
            m_tsc = m_cyc;
        end
        m_tsv = tr;
        if (m_mode == M_UNL) begin
            if (f) begin nc = 0; nm = M_ARM; end
        end else if (m_mode == M_ARM) begin
            if (f) begin m_per = c1; m_pv = 1; bump = 1; nc = 0; nm = M_LCK; end
            else if (m_ms >= TOUT) nm = M_UNL;
        end else if (m_mode == M_LCK) begin
            if (f) begin m_per = c1; bump = 1; nc = 0; end
            else if (m_ms >= TOUT) begin
                nm = M_HLD; bump = 1; m_ho = 1;
                nc = (c1 >= m_per) ? c1 - m_per : 0;
            end
        end else begin
            if (f) begin nm = M_LCK; nc = 0; bump = (m_cyc >= m_per / 2); end
            else if (m_ho >= MAXH) begin nm = M_UNL; m_pv = 0; end
            else if (m_cyc == m_per - 1) begin nc = 0; bump = 1; m_ho = m_ho + 1; end
        end
        if (f || nm != m_mode) m_ms = 0;
        else if (ce && m_ms < TOUT) m_ms = m_ms + 1;
        if (bump) m_sec = (m_sec + 1) % SMOD;
        m_tick = bump;
        m_cyc  = nc;
        m_mode = nm;
    endtask

    task automatic check_model();
        n_tests++;
        if (state_o != 2'(m_mode) || sec_o != 32'(m_sec) || cyc_o != 32'(m_cyc) ||
            period_o != 32'(m_per) || period_valid_o != m_pv || pps_tick_o != m_tick ||
            locked_o != (m_mode == M_LCK) || holdover_o != (m_mode == M_HLD) ||
            ts_sec_o != 32'(m_tss) || ts_cyc_o != 32'(m_tsc) || ts_valid_o != m_tsv) begin
            n_fail++;
            $display("FAIL model t=%0t got st=%0d sec=%0d cyc=%0d per=%0d pv=%0b tick=%0b lk=%0b ho=%0b ts=%0d/%0d/%0b want st=%0d sec=%0d cyc=%0d per=%0d pv=%0b tick=%0b ts=%0d/%0d/%0b",
                     $time, state_o, sec_o, cyc_o, period_o, period_valid_o, pps_tick_o, locked_o,
                     holdover_o, ts_sec_o, ts_cyc_o, ts_valid_o, m_mode, m_sec, m_cyc, m_per, m_pv,
                     m_tick, m_tss, m_tsc, m_tsv);
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (state_o != 0 || sec_o != 0 || cyc_o != 0 || period_o != 0 || period_valid_o != 0 ||
            locked_o != 0 || holdover_o != 0 || pps_tick_o != 0 || ts_sec_o != 0 ||
            ts_cyc_o != 0 || ts_valid_o != 0) begin
            n_fail++;
            $display("FAIL %s got st=%0d sec=%0d cyc=%0d per=%0d pv=%0b tick=%0b ts=%0d/%0d/%0b want all zero",
                     name, state_o, sec_o, cyc_o, period_o, period_valid_o, pps_tick_o,
                     ts_sec_o, ts_cyc_o, ts_valid_o);
        end
    endtask

    // One clock: inputs applied #1 after an edge, model advanced at the edge, outputs checked #1 later.
    task automatic step(input bit f, input bit ce, input bit tr);
        pps_flag_i = f; KHz_CE_i = ce; trig_i = tr;
        @(posedge clk_i);
        model_step(f, ce, tr);
        #1;
        pps_flag_i = 0; KHz_CE_i = 0; trig_i = 0;
        check_model();
    endtask

    // Directed CE cadence: one pulse on every edge whose offset from the last flag ends in 9.
    task automatic dstep(input bit f, input bit tr);
        int k;
        k = since_flag + 1;
        step(f, (k % 10) == 9, tr);
        since_flag = f ? 0 : k;
    endtask

    task automatic do_reset_mid_run();
        rst_n_i = 1'b0;
        #2;
        check_zero("async_reset");
        model_reset();
        since_flag = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    typedef struct {
        bit     rst;
        int     gap;
        bit     flag;
        bit     trig;
        int     st;
        longint sec, cyc, per;
        bit     pv, tick;
        longint tss, tsc;
        bit     tsv;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst gap flag trig | st sec cyc per pv tick tss tsc tsv
        vecs.push_back('{0,   10, 1, 0, 1,  0,    0,    0, 0, 0, 0,   0, 0});
        vecs.push_back('{0, 1000, 1, 0, 2,  1,    0, 1000, 1, 1, 0,   0, 0});
        vecs.push_back('{0, 1000, 1, 0, 2,  2,    0, 1000, 1, 1, 0,   0, 0});
        vecs.push_back('{0, 1000, 1, 0, 2,  3,    0, 1000, 1, 1, 0,   0, 0});
        vecs.push_back('{0, 1000, 1, 0, 2,  4,    0, 1000, 1, 1, 0,   0, 0});
        vecs.push_back('{0, 1000, 1, 0, 2,  5,    0, 1000, 1, 1, 0,   0, 0});
        vecs.push_back('{0, 1000, 1, 1, 2,  6,    0, 1000, 1, 1, 5, 999, 1});
        vecs.push_back('{0,    1, 0, 0, 2,  6,    1, 1000, 1, 0, 5, 999, 0});
        vecs.push_back('{0, 1099, 0, 0, 3,  7,  100, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{0,  900, 0, 0, 3,  8,    0, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{0,  201, 1, 0, 2,  8,    0, 1000, 1, 0, 5, 999, 0});
        vecs.push_back('{0, 1100, 0, 0, 3,  9,  100, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{0,  701, 1, 0, 2, 10,    0, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{0, 1100, 0, 0, 3, 11,  100, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{0,  900, 0, 0, 3, 12,    0, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{0, 1000, 0, 0, 3, 13,    0, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{0,    1, 0, 0, 0, 13,    1, 1000, 0, 0, 5, 999, 0});
        vecs.push_back('{0, 2000, 0, 0, 0, 13, 2001, 1000, 0, 0, 5, 999, 0});
        vecs.push_back('{0,    5, 1, 0, 1, 13,    0, 1000, 0, 0, 5, 999, 0});
        vecs.push_back('{0, 1000, 1, 0, 2, 14,    0, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{0, 1100, 0, 0, 3, 15,  100, 1000, 1, 1, 5, 999, 0});
        vecs.push_back('{1,    3, 1, 0, 1,  0,    0,    0, 0, 0, 0,   0, 0});
        vecs.push_back('{0, 1000, 1, 0, 2,  1,    0, 1000, 1, 1, 0,   0, 0});

        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_zero("reset_state");
        rst_n_i = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].rst) do_reset_mid_run();
            for (int i = 1; i < vecs[v].gap; i++) dstep(0, 0);
            dstep(vecs[v].flag, vecs[v].trig);
            n_tests++;
            if (state_o != 2'(vecs[v].st) || sec_o != 32'(vecs[v].sec) ||
                cyc_o != 32'(vecs[v].cyc) || period_o != 32'(vecs[v].per) ||
                period_valid_o != vecs[v].pv || pps_tick_o != vecs[v].tick ||
                ts_sec_o != 32'(vecs[v].tss) || ts_cyc_o != 32'(vecs[v].tsc) ||
                ts_valid_o != vecs[v].tsv) begin
                n_fail++;
                $display("FAIL vec%0d got st=%0d sec=%0d cyc=%0d per=%0d pv=%0b tick=%0b ts=%0d/%0d/%0b want st=%0d sec=%0d cyc=%0d per=%0d pv=%0b tick=%0b ts=%0d/%0d/%0b",
                         v, state_o, sec_o, cyc_o, period_o, period_valid_o, pps_tick_o,
                         ts_sec_o, ts_cyc_o, ts_valid_o, vecs[v].st, vecs[v].sec, vecs[v].cyc,
                         vecs[v].per, vecs[v].pv, vecs[v].tick, vecs[v].tss, vecs[v].tsc,
                         vecs[v].tsv);
            end
        end

        // Random flag spacing (normal, dropped, glitchy), random CE phase and back-to-back triggers.
        for (int e = 0; e < 60; e++) begin
            int r, gap;
            r = int'($urandom_range(0, 9));
            if (r < 7)      gap = int'($urandom_range(80, 200));
            else if (r < 9) gap = int'($urandom_range(300, 1200));
            else            gap = int'($urandom_range(1, 10));
            for (int i = 0; i < gap; i++) begin
                step(i == gap - 1, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
